// File: rtl/dp_ram_be_clr.sv
// Simple-dual-port RAM with per-byte write enables, 1- or 2-cycle read latency,
// selectable read-during-write result and a hardware clear sweep to INIT_VAL.
module dp_ram_be_clr #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 64,
  parameter int               ADDR_BUS = $clog2(DEPTH),
  parameter int               BE_W     = WIDTH / 8,
  parameter int               RD_LAT   = 1,
  parameter int               RDW_MODE = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  output logic                busy,
  input  logic                we,
  input  logic [ADDR_BUS-1:0] wr_addr,
  input  logic [WIDTH-1:0]    din,
  input  logic [BE_W-1:0]     be,
  input  logic                re,
  input  logic [ADDR_BUS-1:0] rd_addr,
  output logic [WIDTH-1:0]    dout,
  output logic                dout_vld
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [ADDR_BUS-1:0] LAST_ADDR = ADDR_BUS'(DEPTH - 1);
  localparam logic [ADDR_BUS:0]   DEPTH_EXT = (ADDR_BUS + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [ADDR_BUS-1:0] cnt_q, cnt_d;
  logic                s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0]    s1_data_q, s1_data_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                dout_vld_q, dout_vld_d;

  logic             wr_ok, rd_ok, wr_in_range, rd_in_range;
  logic [WIDTH-1:0] lane_mask, rd_word;
  logic             res_vld;
  logic [WIDTH-1:0] res_data;

  assign busy        = (state_q == ST_CLEAR);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
  assign wr_ok       = we && !busy && wr_in_range;
  assign rd_ok       = re && !busy;

  // Sweep sequencer: one word per clock, back to IDLE after writing the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_BUS'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BE_W; i++) lane_mask[8*i +: 8] = {8{be[i]}};
  end

  // Read word, with the incoming write merged in when new-data collision mode is selected.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if (RDW_MODE == 1 && wr_ok && (wr_addr == rd_addr))
        rd_word = (rd_word & ~lane_mask) | (din & lane_mask);
    end
  end

  always_comb begin
    s1_vld_d  = rd_ok;
    s1_data_d = rd_ok ? rd_word : s1_data_q;
    if (RD_LAT == 2) begin
      res_vld  = s1_vld_q;
      res_data = s1_data_q;
    end else begin
      res_vld  = rd_ok;
      res_data = rd_word;
    end
    dout_vld_d = res_vld;
    dout_d     = res_vld ? res_data : dout_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  // Array has no reset so it can map onto block RAM; the sweep provides initialisation.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (wr_ok) begin
      for (int i = 0; i < BE_W; i++)
        if (be[i]) mem[wr_addr][8*i +: 8] <= din[8*i +: 8];
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_dp_ram_be_clr.sv
// Scoreboard bench for dp_ram_be_clr: instance A uses the default parameters,
// instance B is 16-bit, 48 deep, 2-cycle latency, new-data collisions, INIT 16'hFFFF.
module tb_dp_ram_be_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic       rst_a = 1'b0, clr_a = 1'b0, we_a = 1'b0, re_a = 1'b0;
  logic [5:0] wr_addr_a = '0, rd_addr_a = '0;
  logic [7:0] din_a = '0;
  logic [0:0] be_a = '0;
  logic       busy_a, dout_vld_a;
  logic [7:0] dout_a;

  logic        rst_b = 1'b0, clr_b = 1'b0, we_b = 1'b0, re_b = 1'b0;
  logic [5:0]  wr_addr_b = '0, rd_addr_b = '0;
  logic [15:0] din_b = '0;
  logic [1:0]  be_b = '0;
  logic        busy_b, dout_vld_b;
  logic [15:0] dout_b;

  dp_ram_be_clr u_dut_a (
    .clk(clk), .rst(rst_a), .clr(clr_a), .busy(busy_a),
    .we(we_a), .wr_addr(wr_addr_a), .din(din_a), .be(be_a),
    .re(re_a), .rd_addr(rd_addr_a), .dout(dout_a), .dout_vld(dout_vld_a)
  );

  dp_ram_be_clr #(
    .WIDTH(16), .DEPTH(48), .RD_LAT(2), .RDW_MODE(1), .INIT_VAL(16'hFFFF)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .clr(clr_b), .busy(busy_b),
    .we(we_b), .wr_addr(wr_addr_b), .din(din_b), .be(be_b),
    .re(re_b), .rd_addr(rd_addr_b), .dout(dout_b), .dout_vld(dout_vld_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drives one cycle on the selected instance and queues the expected read result.
  task automatic applyStimulus(input bit sel_b, input logic we, input logic [5:0] wa,
                               input logic [15:0] d, input logic [1:0] be,
                               input logic re, input logic [5:0] ra, input logic clr,
                               input logic exp_vld, input logic [15:0] exp);
    exp_t e;
    e.data = exp;
    if (!sel_b) begin
      we_a = we; wr_addr_a = wa; din_a = d[7:0]; be_a = be[0:0];
      re_a = re; rd_addr_a = ra; clr_a = clr;
      if (re && exp_vld) begin
        e.due = cyc + 1;
        q_a.push_back(e);
      end
    end else begin
      we_b = we; wr_addr_b = wa; din_b = d; be_b = be;
      re_b = re; rd_addr_b = ra; clr_b = clr;
      if (re && exp_vld) begin
        e.due = cyc + 2;
        q_b.push_back(e);
      end
    end
    step();
    we_a = 1'b0; re_a = 1'b0; clr_a = 1'b0;
    we_b = 1'b0; re_b = 1'b0; clr_b = 1'b0;
  endtask

  task automatic wr(input bit sel_b, input logic [5:0] a, input logic [15:0] d,
                    input logic [1:0] be);
    applyStimulus(sel_b, 1'b1, a, d, be, 1'b0, 6'd0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic rd(input bit sel_b, input logic [5:0] a, input logic [15:0] exp);
    applyStimulus(sel_b, 1'b0, 6'd0, 16'h0, 2'b00, 1'b1, a, 1'b0, 1'b1, exp);
  endtask

  // Counts clocks until busy drops; optionally fires a write+read to address 0 mid-sweep.
  task automatic wait_sweep(input bit sel_b, input int exp_len, input bit inject,
                            input string name);
    int n = 0;
    while ((sel_b ? busy_b : busy_a) && n < 200) begin
      if (inject && n == 10)
        applyStimulus(sel_b, 1'b1, 6'd0, 16'h12AB, 2'b11, 1'b1, 6'd0, 1'b0, 1'b0, 16'h0);
      else
        step();
      n++;
    end
    checkOutput(name, n, exp_len);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0 && q_a[0].due < cyc) begin
      e = q_a.pop_front();
      checkOutput("a_missing_vld", 32'd0, 32'd1);
    end
    if (dout_vld_a) begin
      if (q_a.size() == 0) begin
        checkOutput("a_unexpected_vld", 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        checkOutput("a_dout", dout_a, e.data);
        checkOutput("a_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q_b.size() > 0 && q_b[0].due < cyc) begin
      e = q_b.pop_front();
      checkOutput("b_missing_vld", 32'd0, 32'd1);
    end
    if (dout_vld_b) begin
      if (q_b.size() == 0) begin
        checkOutput("b_unexpected_vld", 32'd1, 32'd0);
      end else begin
        e = q_b.pop_front();
        checkOutput("b_dout", dout_b, e.data);
        checkOutput("b_latency", cyc, e.due);
      end
    end
  end

  initial begin
    step();
    step();
    checkOutput("a_reset_busy", busy_a, 1);
    checkOutput("a_reset_dout", dout_a, 0);
    checkOutput("a_reset_vld", dout_vld_a, 0);
    checkOutput("b_reset_busy", busy_b, 1);
    checkOutput("b_reset_dout", dout_b, 0);

    // Instance A: power-up sweep, reads, writes, collision, clr and reset mid-sweep.
    rst_a = 1'b1;
    wait_sweep(1'b0, 64, 1'b0, "a_init_sweep_len");
    rd(1'b0, 6'h00, 16'h00);
    rd(1'b0, 6'h20, 16'h00);
    rd(1'b0, 6'h3F, 16'h00);
    wr(1'b0, 6'h01, 16'h11, 2'b01);
    wr(1'b0, 6'h02, 16'h22, 2'b01);
    wr(1'b0, 6'h04, 16'h33, 2'b01);
    wr(1'b0, 6'h20, 16'h66, 2'b01);
    rd(1'b0, 6'h01, 16'h11);
    rd(1'b0, 6'h02, 16'h22);
    rd(1'b0, 6'h04, 16'h33);
    rd(1'b0, 6'h20, 16'h66);
    wr(1'b0, 6'h08, 16'h44, 2'b01);
    applyStimulus(1'b0, 1'b1, 6'h08, 16'h55, 2'b01, 1'b1, 6'h08, 1'b0, 1'b1, 16'h44);
    rd(1'b0, 6'h08, 16'h55);
    applyStimulus(1'b0, 1'b0, 6'h00, 16'h00, 2'b00, 1'b1, 6'h01, 1'b1, 1'b1, 16'h11);
    wait_sweep(1'b0, 64, 1'b1, "a_clr_sweep_len");
    rd(1'b0, 6'h00, 16'h00);
    rd(1'b0, 6'h01, 16'h00);
    wr(1'b0, 6'h3F, 16'h5A, 2'b01);
    rd(1'b0, 6'h3F, 16'h5A);
    applyStimulus(1'b0, 1'b0, 6'h00, 16'h00, 2'b00, 1'b0, 6'h00, 1'b1, 1'b0, 16'h00);
    for (int i = 0; i < 30; i++) step();
    rst_a = 1'b0;
    #1;
    checkOutput("a_midsweep_rst_busy", busy_a, 1);
    checkOutput("a_midsweep_rst_dout", dout_a, 0);
    checkOutput("a_midsweep_rst_vld", dout_vld_a, 0);
    step();
    rst_a = 1'b1;
    wait_sweep(1'b0, 64, 1'b0, "a_restart_sweep_len");
    rd(1'b0, 6'h3F, 16'h00);

    // Instance B: byte enables, 2-cycle latency, merged collisions, out-of-range, clr to FFFF.
    rst_b = 1'b1;
    wait_sweep(1'b1, 48, 1'b0, "b_init_sweep_len");
    rd(1'b1, 6'h00, 16'hFFFF);
    rd(1'b1, 6'h2F, 16'hFFFF);
    wr(1'b1, 6'h05, 16'hAABB, 2'b11);
    wr(1'b1, 6'h05, 16'h1234, 2'b01);
    rd(1'b1, 6'h05, 16'hAA34);
    wr(1'b1, 6'h05, 16'h0000, 2'b00);
    rd(1'b1, 6'h05, 16'hAA34);
    wr(1'b1, 6'h01, 16'h0011, 2'b11);
    wr(1'b1, 6'h02, 16'h0022, 2'b11);
    rd(1'b1, 6'h01, 16'h0011);
    rd(1'b1, 6'h02, 16'h0022);
    wr(1'b1, 6'h08, 16'h0044, 2'b11);
    applyStimulus(1'b1, 1'b1, 6'h08, 16'h5555, 2'b01, 1'b1, 6'h08, 1'b0, 1'b1, 16'h0055);
    rd(1'b1, 6'h08, 16'h0055);
    wr(1'b1, 6'h30, 16'h1234, 2'b11);
    rd(1'b1, 6'h30, 16'h0000);
    rd(1'b1, 6'h3F, 16'h0000);
    rd(1'b1, 6'h00, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, 6'h00, 16'h0000, 2'b00, 1'b1, 6'h01, 1'b1, 1'b1, 16'h0011);
    wait_sweep(1'b1, 48, 1'b1, "b_clr_sweep_len");
    rd(1'b1, 6'h00, 16'hFFFF);
    rd(1'b1, 6'h01, 16'hFFFF);
    rd(1'b1, 6'h05, 16'hFFFF);
    step();
    step();
    applyStimulus(1'b1, 1'b0, 6'h00, 16'h0000, 2'b00, 1'b1, 6'h05, 1'b0, 1'b0, 16'h0000);
    rst_b = 1'b0;
    #1;
    checkOutput("b_rst_inflight_vld", dout_vld_b, 0);
    checkOutput("b_rst_busy", busy_b, 1);
    checkOutput("b_rst_dout", dout_b, 0);
    step();
    step();
    step();
    rst_b = 1'b1;
    wait_sweep(1'b1, 48, 1'b0, "b_restart_sweep_len");

    step();
    step();
    step();
    checkOutput("a_queue_empty", q_a.size(), 0);
    checkOutput("b_queue_empty", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
